// File: rtl/ct_l2c_sram_arb.sv
// Purpose : clears a 4096x144 single-port SRAM after reset, then arbitrates one read and one write requester onto it.
// Latency : requests are granted in the cycle they are presented; read data returns one cycle after grant (two with CT_L2C_SRAM_ARB_OUTREG_EN).
// Backpress: rd_req_rdy/wr_req_rdy stay low until the clear sweep finishes; when both requesters are valid, one is stalled and the turn alternates.
//
// Ports:
//   forever_cpuclk, cpurst_b         clock, asynchronous active-low reset
//   rd_req_vld/addr -> rd_req_rdy    read request handshake (rdy is combinational)
//   wr_req_vld/addr/data/bmask       write request, bmask is a per-bit write enable
//     -> wr_req_rdy
//   rd_data_vld, rd_data             read return, one pulse per granted read, in grant order
//   init_done                        high once every entry has been cleared
//   sram_a/cen/gwen/wen/d, sram_q    SRAM macro pins (cen, gwen and wen are active-low)
// Build option: define CT_L2C_SRAM_ARB_OUTREG_EN to register sram_q before rd_data.
module ct_l2c_sram_arb (
    input  logic         forever_cpuclk,
    input  logic         cpurst_b,
    input  logic         rd_req_vld,
    input  logic [11:0]  rd_req_addr,
    output logic         rd_req_rdy,
    input  logic         wr_req_vld,
    input  logic [11:0]  wr_req_addr,
    input  logic [143:0] wr_req_data,
    input  logic [143:0] wr_req_bmask,
    output logic         wr_req_rdy,
    output logic         rd_data_vld,
    output logic [143:0] rd_data,
    output logic         init_done,
    output logic [11:0]  sram_a,
    output logic         sram_cen,
    output logic         sram_gwen,
    output logic [143:0] sram_wen,
    output logic [143:0] sram_d,
    input  logic [143:0] sram_q
);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t      state;
    logic [11:0] init_cnt;
    // 1: write wins the next contended cycle, 0: read wins it.
    logic        ptr_wr;
    logic        run;
    logic        contend;
    logic        grant_wr;
    logic        grant_rd;
    logic        rd_vld_d1;

    assign run      = (state == ST_RUN);
    assign contend  = rd_req_vld & wr_req_vld;
    assign grant_wr = run & wr_req_vld & (~rd_req_vld | ptr_wr);
    assign grant_rd = run & rd_req_vld & (~wr_req_vld | ~ptr_wr);

    assign wr_req_rdy = grant_wr;
    assign rd_req_rdy = grant_rd;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state     <= ST_RST;
            init_cnt  <= 12'd0;
            init_done <= 1'b0;
            ptr_wr    <= 1'b1;
        end else begin
            case (state)
                ST_RST: begin
                    state <= ST_INIT;
                end
                ST_INIT: begin
                    // Counter parks on the last entry; it never wraps back to 0.
                    if (init_cnt == 12'hFFF) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 12'd1;
                    end
                end
                ST_RUN: begin
                    // The turn only moves when both sides actually competed.
                    if (contend) begin
                        ptr_wr <= ~grant_wr;
                    end
                end
                default: begin
                    state <= ST_RST;
                end
            endcase
        end
    end

    always_comb begin
        sram_a    = 12'd0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_d    = '0;
        if (state == ST_INIT) begin
            sram_a    = init_cnt;
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
        end else if (grant_wr) begin
            sram_a    = wr_req_addr;
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~wr_req_bmask;
            sram_d    = wr_req_data;
        end else if (grant_rd) begin
            sram_a    = rd_req_addr;
            sram_cen  = 1'b0;
        end
    end

    // Read return pipeline. Reset clears the valid stages so reads that were
    // in flight when reset hit are never returned.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_vld_d1 <= 1'b0;
        end else begin
            rd_vld_d1 <= grant_rd;
        end
    end

`ifdef CT_L2C_SRAM_ARB_OUTREG_EN
    logic         rd_vld_d2;
    logic [143:0] rd_data_q;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_vld_d2 <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_d2 <= rd_vld_d1;
            // Capture only real returns so rd_data holds between valid pulses.
            if (rd_vld_d1) begin
                rd_data_q <= sram_q;
            end
        end
    end

    assign rd_data_vld = rd_vld_d2;
    assign rd_data     = rd_data_q;
`else
    assign rd_data_vld = rd_vld_d1;
    // Gate the macro output so rd_data reads as zero outside a return.
    assign rd_data     = rd_vld_d1 ? sram_q : '0;
`endif

endmodule
